updi_output_handler: RTL and testbench

//  Transmit side of the UPDI byte path. On start it writes an optional SYNCH byte (0x55),
//  an opcode byte and n_bytes payload bytes into the UART TX FIFO. Payload bytes are taken

---
 rtl/updi_output_handler.sv | 163 ++++++++++++++++
 tb/tb_updi_output_handler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/updi_output_handler.sv
// UPDI transmit path: SYNCH/opcode/payload bytes into the UART TX FIFO, with each
// single-wire echo read back from the RX FIFO and compared before the next byte goes out.
module updi_output_handler #(
    parameter int BITS_N       = 6,
    parameter bit ECHO_CHECK   = 1'b1,
    parameter int TIMEOUT_BITS = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              send_sync,
    input  logic [7:0]        opcode,
    input  logic [BITS_N-1:0] n_bytes,
    output logic              ready,
    output logic              done,
    output logic              echo_error,
    output logic              echo_timeout,
    input  logic [7:0]        src_fifo_data,
    input  logic              src_fifo_empty,
    output logic              src_fifo_rd_en,
    output logic [7:0]        tx_fifo_data,
    input  logic              tx_fifo_full,
    output logic              tx_fifo_wr_en,
    input  logic [7:0]        rx_fifo_data,
    input  logic              rx_fifo_empty,
    output logic              rx_fifo_rd_en
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SYNC     = 3'd1;
    localparam logic [2:0] S_OPCODE   = 3'd2;
    localparam logic [2:0] S_PL_READ  = 3'd3;
    localparam logic [2:0] S_PL_WRITE = 3'd4;
    localparam logic [2:0] S_ECHO     = 3'd5;
    localparam logic [2:0] S_ECHO_CHK = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    localparam logic [7:0]              SYNCH_BYTE = 8'h55;
    localparam logic [BITS_N-1:0]       CNT_ONE    = BITS_N'(1);
    localparam logic [TIMEOUT_BITS-1:0] TMO_ONE    = TIMEOUT_BITS'(1);
    // Last value before all-ones: the increment that reaches all-ones is the timeout.
    localparam logic [TIMEOUT_BITS-1:0] TMO_LAST   = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

    logic [2:0]              state;
    logic [2:0]              ret_state;
    logic [7:0]              opcode_q;
    logic [BITS_N-1:0]       n_bytes_q;
    logic [BITS_N-1:0]       count;
    logic [7:0]              last_tx;
    logic [TIMEOUT_BITS-1:0] tmo;
    logic [2:0]              after_opcode;

    assign after_opcode = (n_bytes_q == '0) ? S_DONE : S_PL_READ;

    assign ready = (state == S_IDLE) || (state == S_DONE);
    assign done  = (state == S_DONE);

    always_comb begin
        tx_fifo_data   = 8'h00;
        tx_fifo_wr_en  = 1'b0;
        src_fifo_rd_en = 1'b0;
        rx_fifo_rd_en  = 1'b0;
        case (state)
            S_SYNC: begin
                tx_fifo_data  = SYNCH_BYTE;
                tx_fifo_wr_en = !tx_fifo_full;
            end
            S_OPCODE: begin
                tx_fifo_data  = opcode_q;
                tx_fifo_wr_en = !tx_fifo_full;
            end
            S_PL_READ:  src_fifo_rd_en = !src_fifo_empty;
            S_PL_WRITE: begin
                tx_fifo_data  = src_fifo_data;
                tx_fifo_wr_en = !tx_fifo_full;
            end
            S_ECHO:     rx_fifo_rd_en = !rx_fifo_empty;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            ret_state    <= S_IDLE;
            opcode_q     <= 8'h00;
            n_bytes_q    <= '0;
            count        <= '0;
            last_tx      <= 8'h00;
            tmo          <= '0;
            echo_error   <= 1'b0;
            echo_timeout <= 1'b0;
        end else begin
            if (tx_fifo_wr_en)
                last_tx <= tx_fifo_data;
            if (state != S_ECHO)
                tmo <= '0;

            // With echo checking disabled, every write jumps straight to its return state.
            case (state)
                S_IDLE: begin
                    if (start) begin
                        opcode_q     <= opcode;
                        n_bytes_q    <= n_bytes;
                        count        <= n_bytes;
                        echo_error   <= 1'b0;
                        echo_timeout <= 1'b0;
                        state        <= send_sync ? S_SYNC : S_OPCODE;
                    end
                end
                S_SYNC: begin
                    if (tx_fifo_wr_en) begin
                        ret_state <= S_OPCODE;
                        state     <= ECHO_CHECK ? S_ECHO : S_OPCODE;
                    end
                end
                S_OPCODE: begin
                    if (tx_fifo_wr_en) begin
                        ret_state <= after_opcode;
                        state     <= ECHO_CHECK ? S_ECHO : after_opcode;
                    end
                end
                S_PL_READ: begin
                    if (!src_fifo_empty)
                        state <= S_PL_WRITE;
                end
                S_PL_WRITE: begin
                    if (tx_fifo_wr_en) begin
                        if (count == CNT_ONE) begin
                            ret_state <= S_DONE;
                            state     <= ECHO_CHECK ? S_ECHO : S_DONE;
                        end else begin
                            count     <= count - CNT_ONE;
                            ret_state <= S_PL_READ;
                            state     <= ECHO_CHECK ? S_ECHO : S_PL_READ;
                        end
                    end
                end
                S_ECHO: begin
                    if (!rx_fifo_empty) begin
                        state <= S_ECHO_CHK;
                    end else begin
                        tmo <= tmo + TMO_ONE;
                        if (tmo == TMO_LAST) begin
                            echo_timeout <= 1'b1;
                            state        <= S_DONE;
                        end
                    end
                end
                S_ECHO_CHK: begin
                    if (rx_fifo_data != last_tx) begin
                        echo_error <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        state <= ret_state;
                    end
                end
                S_DONE: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_updi_output_handler.sv
// Bench for updi_output_handler: FIFO models around the DUT, directed cases plus random transfers.
module tb_updi_output_handler;
    localparam int BITS_N = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              send_sync = 1'b0;
    logic [7:0]        opcode = 8'h00;
    logic [BITS_N-1:0] n_bytes = '0;
    logic              ready, done, echo_error, echo_timeout;
    logic [7:0]        src_fifo_data = 8'h00;
    logic              src_fifo_empty = 1'b1;
    logic              src_fifo_rd_en;
    logic [7:0]        tx_fifo_data;
    logic              tx_fifo_full = 1'b0;
    logic              tx_fifo_wr_en;
    logic [7:0]        rx_fifo_data = 8'h00;
    logic              rx_fifo_empty = 1'b1;
    logic              rx_fifo_rd_en;

    always #5 clk = ~clk;

    updi_output_handler #(.BITS_N(BITS_N), .ECHO_CHECK(1'b1), .TIMEOUT_BITS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .send_sync(send_sync), .opcode(opcode),
        .n_bytes(n_bytes), .ready(ready), .done(done), .echo_error(echo_error),
        .echo_timeout(echo_timeout), .src_fifo_data(src_fifo_data),
        .src_fifo_empty(src_fifo_empty), .src_fifo_rd_en(src_fifo_rd_en),
        .tx_fifo_data(tx_fifo_data), .tx_fifo_full(tx_fifo_full),
        .tx_fifo_wr_en(tx_fifo_wr_en), .rx_fifo_data(rx_fifo_data),
        .rx_fifo_empty(rx_fifo_empty), .rx_fifo_rd_en(rx_fifo_rd_en)
    );

    logic [7:0] src_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] tx_log[$];
    logic [7:0] pl[$];
    logic [7:0] exp_q[$];
    int src_reads, rx_reads, done_cnt, full_viol, cyc, last_wr_cyc, done_cyc;
    int corrupt_idx = -1, full_after = -1, full_left = 0;
    bit rx_drop, force_full, rand_full, rand_stall;
    int n_pass = 0, n_checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: sample strobes mid-cycle, then update the FIFO models just after the edge.
    task automatic tick();
        logic wr, sr, rr, d;
        logic [7:0] wd;
        @(negedge clk);
        wr = tx_fifo_wr_en; wd = tx_fifo_data; sr = src_fifo_rd_en;
        rr = rx_fifo_rd_en; d = done;
        if (wr && tx_fifo_full) full_viol++;
        @(posedge clk);
        #1;
        cyc++;
        if (sr) begin
            src_reads++;
            if (src_q.size() > 0) src_fifo_data = src_q.pop_front();
        end
        if (rr) begin
            rx_reads++;
            if (rx_q.size() > 0) rx_fifo_data = rx_q.pop_front();
        end
        if (full_left > 0) full_left--;
        if (wr) begin
            tx_log.push_back(wd);
            last_wr_cyc = cyc;
            if (!rx_drop)
                rx_q.push_back((tx_log.size() - 1 == corrupt_idx) ? (wd ^ 8'h01) : wd);
            if (tx_log.size() == full_after) full_left = 5;
        end
        if (d) begin
            done_cnt++;
            done_cyc = cyc;
        end
        tx_fifo_full   = force_full || (full_left > 0) || (rand_full && $urandom_range(0, 3) == 0);
        src_fifo_empty = (src_q.size() == 0) || (rand_stall && $urandom_range(0, 2) == 0);
        rx_fifo_empty  = (rx_q.size() == 0);
    endtask

    task automatic reset_model();
        src_q.delete(); rx_q.delete(); tx_log.delete();
        src_reads = 0; rx_reads = 0; done_cnt = 0; full_viol = 0;
        last_wr_cyc = 0; done_cyc = 0;
        corrupt_idx = -1; full_after = -1; full_left = 0;
        rx_drop = 0; force_full = 0; rand_full = 0; rand_stall = 0;
        tx_fifo_full = 1'b0;
        rx_fifo_empty = 1'b1;
        src_fifo_empty = 1'b1;
    endtask

    task automatic load_src();
        src_q = pl;
        src_fifo_empty = (src_q.size() == 0);
    endtask

    task automatic run_xfer(input string tag, input bit ss, input logic [7:0] op, input bit hold);
        int n;
        n = pl.size();
        send_sync = ss; opcode = op; n_bytes = n[BITS_N-1:0]; start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        chk({tag, "_busy"}, {ready, echo_error, echo_timeout}, 3'b000);
        for (int i = 0; i < 3000 && done_cnt == 0; i++) tick();
        start = 1'b0;
        if (done_cnt == 0) chk({tag, "_done_budget"}, 0, 1);
    endtask

    // Expected outcome built from the byte list the transfer should produce.
    task automatic check_xfer(input string tag, input bit ss, input logic [7:0] op);
        int hdr, exp_src, exp_rx;
        tick();
        exp_q.delete();
        if (ss) exp_q.push_back(8'h55);
        exp_q.push_back(op);
        hdr = exp_q.size();
        foreach (pl[i]) exp_q.push_back(pl[i]);
        if (rx_drop) while (exp_q.size() > 1) void'(exp_q.pop_back());
        if (corrupt_idx >= 0) while (exp_q.size() > corrupt_idx + 1) void'(exp_q.pop_back());
        exp_src = (exp_q.size() > hdr) ? exp_q.size() - hdr : 0;
        exp_rx  = rx_drop ? 0 : exp_q.size();
        chk({tag, "_tx_count"}, tx_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
            chk($sformatf("%s_tx_byte%0d", tag, i), tx_log[i], exp_q[i]);
        chk({tag, "_src_reads"}, src_reads, exp_src);
        chk({tag, "_rx_reads"}, rx_reads, exp_rx);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_echo_error"}, echo_error, corrupt_idx >= 0);
        chk({tag, "_echo_timeout"}, echo_timeout, rx_drop);
        chk({tag, "_ready"}, ready, 1'b1);
        chk({tag, "_wr_while_full"}, full_viol, 0);
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, {ready, done, tx_fifo_wr_en, src_fifo_rd_en, rx_fifo_rd_en,
                  echo_error, echo_timeout}, 7'b1000000);
    endtask

    initial begin
        logic [7:0] op;
        bit ss;
        int n;
        reset_model();
        rst = 1'b1;
        tick(); tick();
        chk_quiet("reset_state");
        rst = 1'b0;
        tick();
        chk_quiet("idle_after_reset");

        // 1: SYNCH + opcode only
        reset_model(); pl.delete(); load_src();
        run_xfer("t1", 1'b1, 8'h80, 1'b0);
        check_xfer("t1", 1'b1, 8'h80);

        // 2: three payload bytes
        reset_model(); pl = '{8'h11, 8'h22, 8'h33}; load_src();
        run_xfer("t2", 1'b0, 8'h64, 1'b0);
        check_xfer("t2", 1'b0, 8'h64);

        // 3: TX FIFO full for 5 cycles after the first payload byte
        reset_model(); pl = '{8'hA1, 8'hA2, 8'hA3, 8'hA4}; load_src();
        full_after = 2;
        run_xfer("t3", 1'b0, 8'h3C, 1'b0);
        check_xfer("t3", 1'b0, 8'h3C);

        // 4: second payload echo corrupted, then a clean transfer clears the flag
        reset_model(); pl = '{8'h11, 8'h22, 8'h33}; load_src();
        corrupt_idx = 2;
        run_xfer("t4", 1'b0, 8'h64, 1'b0);
        check_xfer("t4", 1'b0, 8'h64);
        chk("t4_echo_error_sticky", echo_error, 1'b1);
        reset_model(); pl = '{8'h11, 8'h22, 8'h33}; load_src();
        run_xfer("t4b", 1'b0, 8'h64, 1'b0);
        check_xfer("t4b", 1'b0, 8'h64);

        // 5: echo never arrives
        reset_model(); pl.delete(); load_src();
        rx_drop = 1'b1;
        run_xfer("t5", 1'b0, 8'h80, 1'b0);
        chk("t5_timeout_latency", done_cyc - last_wr_cyc, 8);
        check_xfer("t5", 1'b0, 8'h80);

        // 6: reset while parked in the payload write state
        reset_model(); pl = '{8'h11, 8'h22, 8'h33}; load_src();
        send_sync = 1'b0; opcode = 8'h64; n_bytes = 6'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && src_reads == 0; i++) tick();
        chk("t6_reached_payload", src_reads, 1);
        force_full = 1'b1; tx_fifo_full = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; force_full = 1'b0; tx_fifo_full = 1'b0;
        chk_quiet("t6_after_rst");
        tick(); tick(); tick();
        chk_quiet("t6_idle");
        chk("t6_no_more_writes", tx_log.size(), 1);
        chk("t6_no_done", done_cnt, 0);
        chk("t6_no_more_src_reads", src_reads, 1);
        reset_model(); pl = '{8'h11, 8'h22, 8'h33}; load_src();
        run_xfer("t6b", 1'b0, 8'h64, 1'b0);
        check_xfer("t6b", 1'b0, 8'h64);

        // Random transfers with stalls, held start and occasional corrupted echoes
        for (int t = 0; t < 30; t++) begin
            reset_model();
            ss = 1'($urandom_range(0, 1));
            op = 8'($urandom);
            n = $urandom_range(0, 12);
            pl.delete();
            for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
            load_src();
            rand_full = 1'b1; rand_stall = 1'b1;
            if ($urandom_range(0, 3) == 0) corrupt_idx = $urandom_range(0, n + int'(ss));
            run_xfer($sformatf("rnd%0d", t), ss, op, 1'($urandom_range(0, 1)));
            check_xfer($sformatf("rnd%0d", t), ss, op);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
